riscv_fetch: RTL and testbench
==============================

Name: riscv_fetch

Overview:
- Instruction-fetch stage directly upstream of the riscv decode/register-read stage.
- Owns the program counter and issues word reads to instruction memory over a valid/ready request channel.
- Accepts in-order responses, buffers {pc, instruction} pairs in a small FIFO and presents them to decode on a valid/ready handshake.
- Handles redirects (branch/jump) from downstream by flushing the buffer and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset; bits [1:0] must be 0.
- DEPTH, 2, FIFO entries; also the maximum outstanding plus buffered instructions; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  read data valid; always accepted, no backpressure.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  downstream branch/jump taken.
- redirect_pc  in  32  new PC; bits [1:0] forced to 0 internally.
- ir_valid  out  1  instruction available to decode.
- ir_ready  in  1  decode accepts instruction.
- ir  out  32  instruction word (FIFO head).
- ir_pc  out  32  PC of the instruction on ir.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - imem_req_valid=0, ir_valid=0, ir=0, ir_pc=0.
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - outstanding=0, drop_cnt=0, FIFO empty, state=BOOT.
- Reset mid-operation discards everything; responses arriving for pre-reset requests are the memory's responsibility (memory is reset together with this block).
- FSM states:
  - BOOT: held exactly one cycle after reset release; no request; goes to RUN.
  - RUN: normal fetching.
  - DRAIN: stale responses outstanding after a redirect; no new requests; goes to RUN in the cycle drop_cnt becomes 0.
- Request issue (combinational valid, registered state):
  - imem_req_valid = (state==RUN) && !redirect_valid && (outstanding + fifo_count < DEPTH).
  - imem_req_addr = fetch_pc.
  - On a req handshake: fetch_pc += 4 (wraps mod 2^32), outstanding++.
- Response:
  - If drop_cnt>0, the response is discarded: drop_cnt--, outstanding--.
  - Otherwise push {rsp_pc, imem_rsp_data} into the FIFO, rsp_pc += 4, outstanding--.
  - Responses return in request order; the credit rule guarantees the FIFO never overflows. A push to a full FIFO is an assertion failure.
- Decode side:
  - ir_valid = FIFO non-empty; ir and ir_pc show the head entry.
  - Pop on ir_valid && ir_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including empty→bypass-free: a pushed entry is visible the next cycle. Latency from response to ir_valid is 1 cycle.
- Redirect (redirect_valid=1), registered on that edge:
  - FIFO flushed.
  - fetch_pc = rsp_pc = {redirect_pc[31:2],2'b00}.
  - Any request in that cycle is suppressed (imem_req_valid forced 0).
  - A response arriving in the same cycle is treated as stale and dropped.
  - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0), including any already-pending drop_cnt.
  - State = DRAIN if the new drop_cnt > 0, else RUN.
  - An ir handshake in the same cycle completes (decode consumed it); all other entries are lost.
  - A redirect during BOOT is applied; state then goes to RUN or DRAIN as above.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Counter widths: outstanding, drop_cnt and fifo_count are $clog2(DEPTH+1) bits. An underflow (response with outstanding=0) is an assertion failure.
- PC arithmetic is 32-bit unsigned with wrap: 32'hFFFF_FFFC+4 → 0.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants (ROP, IOP, SOP, BOP, UOP, JOP) and ALU op codes.
  - The fetch FSM state enum (BOOT, RUN, DRAIN).
  - A fetch-packet typedef {pc[31:0], instr[31:0]}.
  - The NOP encoding 32'h0000_0013.
- One natural sub-module: fetch_fifo (parameterized DEPTH × 64-bit, synchronous flush, push/pop/full/empty/count).

Test Plan:
- Reset release with memory always ready and 1-cycle response latency -> first req addr 0x0 at cycle 2 after release; decode with ir_ready=1 sees pc 0x0,0x4,0x8… with memory data, one per cycle in steady state.
- ir_ready=0 for 10 cycles -> at most DEPTH(=2) requests issued, FIFO holds pc 0x0,0x4, no further req; ir_ready=1 -> fetching resumes at 0x8 with no lost or duplicated pc.
- Redirect to 0x100 while 2 requests are outstanding -> FIFO empty next cycle; 2 responses dropped (never appear on ir); state DRAIN; next req addr 0x100; ir_pc 0x100 is the first visible instruction.
- Redirect coincident with imem_rsp_valid and one other outstanding -> drop_cnt=1; the coincident word and the following word are discarded; redirect_pc=0x203 yields fetch address 0x200.
- Redirect to 0xFFFF_FFFC -> fetch sequence 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Assert rst low mid-burst with 2 outstanding and FIFO full -> outputs drop to reset values immediately (asynchronous); after release the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: base opcodes, ALU operation codes,
// fetch FSM states and the {pc, instr} packet passed from fetch to decode.
package riscv_pkg;

    localparam logic [6:0] ROP = 7'b0110011;
    localparam logic [6:0] IOP = 7'b0010011;
    localparam logic [6:0] SOP = 7'b0100011;
    localparam logic [6:0] BOP = 7'b1100011;
    localparam logic [6:0] UOP = 7'b0110111;
    localparam logic [6:0] JOP = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Small FIFO of fetch packets between the instruction-memory response path
// and decode. Flush is synchronous and takes priority over push/pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_pkt_t       push_data_i,
    input  logic             pop_i,
    output fetch_pkt_t       head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_pkt_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage is cleared on reset so the decode-facing outputs read as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word reads,
// buffers in-order responses for decode and discards stale data after redirects.
module riscv_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    typedef logic [CNT_W-1:0] cnt_t;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  rsp_pc_q, rsp_pc_d;
    cnt_t         outstanding_q, outstanding_d;
    cnt_t         drop_cnt_q, drop_cnt_d;

    cnt_t         fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_pkt_t   fifo_head;
    fetch_pkt_t   fifo_push_data;
    logic         fifo_push;
    logic         fifo_pop;

    logic         credit_ok;
    logic         req_fire;
    logic [31:0]  redirect_target;

    assign redirect_target = redirect_pc & ~32'h0000_0003;

    // Outstanding requests plus buffered entries never exceed DEPTH, so every response has a slot.
    assign credit_ok      = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < CREDIT_LIMIT;
    assign imem_req_valid = (state_q == RUN) && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign fifo_push      = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
    assign fifo_push_data = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign fifo_pop       = ir_valid && ir_ready;

    assign ir_valid = !fifo_empty;
    assign ir       = fifo_head.instr;
    assign ir_pc    = fifo_head.pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);

        if (redirect_valid) begin
            // No request fires here, so whatever remains in flight after this edge is stale.
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            drop_cnt_d = outstanding_d;
            state_d    = (outstanding_d != '0) ? DRAIN : RUN;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - cnt_t'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + 32'd4;
                end
            end
            unique case (state_q)
                BOOT:    state_d = RUN;
                DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst) !(fifo_push && fifo_full));
    assert property (@(posedge clk) disable iff (!rst) !(imem_rsp_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_riscv_fetch.sv
// Scoreboarded bench for riscv_fetch: in-order fetch, decode stall, redirects
// (including coincident response and PC wrap) and asynchronous reset.
module tb_riscv_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;

    logic        memHold;
    logic [31:0] expQ[$];
    logic [31:0] reqLog[$];
    logic [31:0] memQ[$];
    int          errCount   = 0;
    int          checkCount = 0;

    riscv_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .ir_pc          (ir_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] logAt(input int idx);
        if (idx < reqLog.size()) return reqLog[idx];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic hold, input logic redirValid, input logic [31:0] redirPc);
        ir_ready       = ready;
        memHold        = hold;
        redirect_valid = redirValid;
        redirect_pc    = redirPc;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checkCount++;
            errCount++;
            $display("[TB] FAIL drain_timeout: got %0d instructions still pending, expected 0", expQ.size());
            expQ.delete();
        end
        ir_ready = 1'b0;
    endtask

    // Memory: always-ready, in-order, one-cycle latency unless memHold parks responses.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            memQ.delete();
            reqLog.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                memQ.push_back(imem_req_addr);
                reqLog.push_back(imem_req_addr);
            end
            if (!memHold && memQ.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= memData(memQ.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    // Decode-side monitor: every handshake must match the next expected PC and its memory word.
    initial begin
        logic [31:0] expPc;
        forever begin
            @(negedge clk);
            #1;
            if (rst && ir_valid && ir_ready) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    errCount++;
                    $display("[TB] FAIL unexpected_ir: got pc 0x%08h, expected no instruction", ir_pc);
                end else begin
                    expPc = expQ.pop_front();
                    checkOutput("ir_pc", ir_pc, expPc);
                    checkOutput("ir_data", ir, memData(expPc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #2;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("rst_ir", ir, 32'd0);
        checkOutput("rst_ir_pc", ir_pc, 32'd0);

        $display("[TB] in-order fetch from reset");
        for (int i = 0; i < 12; i++) expQ.push_back(32'(i * 4));
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("boot_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        #2;
        checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("first_req_addr", imem_req_addr, 32'h0);
        waitDrain(100);
        checkOutput("first_logged_addr", logAt(0), 32'h0);

        $display("[TB] decode stall");
        resetDut();
        repeat (10) @(negedge clk);
        #2;
        checkOutput("stall_req_count", 32'(reqLog.size()), 32'd2);
        checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("stall_ir_valid", 32'(ir_valid), 32'd1);
        checkOutput("stall_head_pc", ir_pc, 32'h0);
        checkOutput("stall_head_ir", ir, memData(32'h0));
        @(negedge clk);
        for (int i = 0; i < 4; i++) expQ.push_back(32'(i * 4));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        waitDrain(100);

        $display("[TB] redirect with two requests in flight");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        resetDut();
        repeat (5) @(negedge clk);
        #2;
        checkOutput("held_req_count", 32'(reqLog.size()), 32'd2);
        checkOutput("held_ir_valid", 32'(ir_valid), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) expQ.push_back(32'h100 + 32'(i * 4));
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        #2;
        checkOutput("redir_req_suppressed", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("redir_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("drain_req_a", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        #2;
        checkOutput("drain_req_b", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        #2;
        checkOutput("post_drain_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("post_drain_req_addr", imem_req_addr, 32'h100);
        waitDrain(100);
        checkOutput("redir_logged_addr", logAt(2), 32'h100);

        $display("[TB] redirect coincident with a response");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        resetDut();
        repeat (5) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) expQ.push_back(32'h200 + 32'(i * 4));
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0203);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("coinc_drain_req", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        #2;
        checkOutput("coinc_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("coinc_req_addr", imem_req_addr, 32'h200);
        waitDrain(100);
        checkOutput("coinc_logged_addr", logAt(2), 32'h200);

        $display("[TB] flush of a full buffer and PC wrap");
        repeat (8) @(negedge clk);
        #2;
        checkOutput("full_ir_valid", 32'(ir_valid), 32'd1);
        checkOutput("full_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        expQ.push_back(32'hFFFF_FFFC);
        expQ.push_back(32'h0000_0000);
        expQ.push_back(32'h0000_0004);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("flush_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        waitDrain(100);

        $display("[TB] asynchronous reset with a full buffer");
        repeat (8) @(negedge clk);
        #2;
        checkOutput("pre_reset_ir_valid", 32'(ir_valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("async_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("async_ir", ir, 32'd0);
        checkOutput("async_ir_pc", ir_pc, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) expQ.push_back(32'(i * 4));
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        waitDrain(100);
        checkOutput("restart_logged_addr", logAt(0), 32'h0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
